// File: rtl/tpu_pkg.sv
// Shared types and constants for the host-side matmul sequencer.
package tpu_pkg;

    // Sequencer phases, in the order a job walks through them.
    typedef enum logic [2:0] {
        LOAD      = 3'd0,
        WAIT_DONE = 3'd1,
        WAIT_READ = 3'd2,
        READ      = 3'd3,
        DRAIN     = 3'd4
    } seq_state_t;

    localparam int JOB_BYTES   = 8;
    localparam int NUM_RESULTS = 4;
    localparam int IDX_W       = 2;
    localparam int BYTE_W      = $clog2(JOB_BYTES);
    // Width of the timeout and read-delay counters.
    localparam int CNT_W       = 8;

endpackage

// File: rtl/tpu_result_buf.sv
// Four-entry result buffer: indexed write port, sequential read pointer.
module tpu_result_buf
    import tpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rd_inc_i,
    output logic [IDX_W-1:0] rd_ptr_o,
    output logic [7:0]       rd_data_o
);

    logic [7:0]       mem_q [NUM_RESULTS];
    logic [IDX_W-1:0] rd_ptr_q;

    // Capture one result per write strobe into the addressed slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_RESULTS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    // Read pointer wraps 3 -> 0 so it is back at slot 0 for the next job.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
        end else if (rd_inc_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign rd_ptr_o  = rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/tpu_host_sequencer.sv
// Host-side initiator for the 2x2 matmul controller byte interface.
// Loads an 8-byte job, waits for done, reads four results back-to-back and
// returns them on a valid/ready stream.
//
// Handshakes: a byte/beat transfers on a rising edge where valid && ready.
// s_ready is high only in LOAD and m_valid only in DRAIN; both depend on
// state alone, never on the partner's valid/ready. The producer holds data
// stable while valid && !ready.
module tpu_host_sequencer
    import tpu_pkg::*;
#(
    parameter int READ_DELAY = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             ctl_load_en,
    output logic             ctl_load_sel_ab,
    output logic [IDX_W-1:0] ctl_load_index,
    output logic [7:0]       ctl_in_data,
    output logic             ctl_output_en,
    output logic [IDX_W-1:0] ctl_output_sel,
    input  logic [7:0]       ctl_out_data,
    input  logic             ctl_done,
    output logic             busy,
    output logic             timeout_err,
    output seq_state_t       dbg_state_o
);

    seq_state_t        state_q;
    logic [BYTE_W-1:0] byte_cnt_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic [CNT_W-1:0]  dly_cnt_q;
    logic              load_en_q;
    logic              load_sel_ab_q;
    logic [IDX_W-1:0]  load_index_q;
    logic [7:0]        in_data_q;
    logic              output_en_q;
    logic [IDX_W-1:0]  output_sel_q;
    logic              timeout_err_q;

    logic              s_hs;
    logic              m_hs;
    logic [IDX_W-1:0]  drain_idx;

    assign s_hs = s_valid && s_ready;
    assign m_hs = m_valid && m_ready;

    // Sequencer FSM with its registered controller-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= LOAD;
            byte_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            dly_cnt_q     <= '0;
            load_en_q     <= 1'b0;
            load_sel_ab_q <= 1'b0;
            load_index_q  <= '0;
            in_data_q     <= '0;
            output_en_q   <= 1'b0;
            output_sel_q  <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            load_en_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (s_hs) begin
                        load_en_q     <= 1'b1;
                        load_sel_ab_q <= byte_cnt_q[2];
                        load_index_q  <= byte_cnt_q[1:0];
                        in_data_q     <= s_data;
                        byte_cnt_q    <= byte_cnt_q + 1'b1;
                        if (byte_cnt_q == BYTE_W'(JOB_BYTES - 1)) begin
                            state_q   <= WAIT_DONE;
                            tmo_cnt_q <= '0;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (ctl_done) begin
                        dly_cnt_q <= CNT_W'(1);
                        if (READ_DELAY <= 1) begin
                            state_q      <= READ;
                            output_en_q  <= 1'b1;
                            output_sel_q <= '0;
                        end else begin
                            state_q <= WAIT_READ;
                        end
                    end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Controller never answered: drop the job, flag it.
                        timeout_err_q <= 1'b1;
                        state_q       <= LOAD;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                WAIT_READ: begin
                    if (dly_cnt_q == CNT_W'(READ_DELAY - 1)) begin
                        state_q      <= READ;
                        output_en_q  <= 1'b1;
                        output_sel_q <= '0;
                    end else begin
                        dly_cnt_q <= dly_cnt_q + 1'b1;
                    end
                end
                READ: begin
                    // Reads run unconditionally: the controller clears its
                    // array mid-sequence, so they may not wait on m_ready.
                    if (output_sel_q == IDX_W'(NUM_RESULTS - 1)) begin
                        output_en_q  <= 1'b0;
                        output_sel_q <= '0;
                        state_q      <= DRAIN;
                    end else begin
                        output_sel_q <= output_sel_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_hs && drain_idx == IDX_W'(NUM_RESULTS - 1)) begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    tpu_result_buf u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (output_en_q),
        .wr_idx_i  (output_sel_q),
        .wr_data_i (ctl_out_data),
        .rd_inc_i  (m_hs),
        .rd_ptr_o  (drain_idx),
        .rd_data_o (m_data)
    );

    assign s_ready         = (state_q == LOAD);
    assign m_valid         = (state_q == DRAIN);
    assign m_last          = m_valid && (drain_idx == IDX_W'(NUM_RESULTS - 1));
    assign busy            = (state_q != LOAD);
    assign ctl_load_en     = load_en_q;
    assign ctl_load_sel_ab = load_sel_ab_q;
    assign ctl_load_index  = load_index_q;
    assign ctl_in_data     = in_data_q;
    assign ctl_output_en   = output_en_q;
    assign ctl_output_sel  = output_sel_q;
    assign timeout_err     = timeout_err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Directed bench for tpu_host_sequencer: a READ_DELAY=2 instance and a
// READ_DELAY=3 instance share stimulus; use_b selects which one is observed.
`timescale 1ns/1ps
module tb_tpu_host_sequencer;
    import tpu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst3 = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus / DUT signals ----------------
    logic        s_valid  = 1'b0;
    logic [7:0]  s_data   = 8'h00;
    logic        m_ready  = 1'b0;
    logic        ctl_done = 1'b0;
    logic [7:0]  ctl_out_data;
    logic [31:0] bfm_res  = 32'h0;
    logic        use_b    = 1'b0;

    logic a_s_ready, a_m_valid, a_m_last, a_load_en, a_sel_ab, a_output_en, a_busy, a_tmo;
    logic [7:0] a_m_data, a_in_data;
    logic [1:0] a_index, a_out_sel;
    seq_state_t a_state;
    logic b_s_ready, b_m_valid, b_m_last, b_load_en, b_sel_ab, b_output_en, b_busy, b_tmo;
    logic [7:0] b_m_data, b_in_data;
    logic [1:0] b_index, b_out_sel;
    seq_state_t b_state;

    tpu_host_sequencer #(.READ_DELAY(2), .TIMEOUT(15)) u_dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_data(a_m_data), .m_last(a_m_last),
        .ctl_load_en(a_load_en), .ctl_load_sel_ab(a_sel_ab), .ctl_load_index(a_index),
        .ctl_in_data(a_in_data), .ctl_output_en(a_output_en), .ctl_output_sel(a_out_sel),
        .ctl_out_data(ctl_out_data), .ctl_done(ctl_done), .busy(a_busy),
        .timeout_err(a_tmo), .dbg_state_o(a_state)
    );

    tpu_host_sequencer #(.READ_DELAY(3), .TIMEOUT(15)) u_dut_rd3 (
        .clk(clk), .rst(rst3), .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_data(b_m_data), .m_last(b_m_last),
        .ctl_load_en(b_load_en), .ctl_load_sel_ab(b_sel_ab), .ctl_load_index(b_index),
        .ctl_in_data(b_in_data), .ctl_output_en(b_output_en), .ctl_output_sel(b_out_sel),
        .ctl_out_data(ctl_out_data), .ctl_done(ctl_done), .busy(b_busy),
        .timeout_err(b_tmo), .dbg_state_o(b_state)
    );

    // Observed instance.
    logic o_rst, o_s_ready, o_m_valid, o_m_last, o_load_en, o_sel_ab, o_output_en, o_busy, o_tmo;
    logic [7:0] o_m_data, o_in_data;
    logic [1:0] o_index, o_out_sel;
    seq_state_t o_state;
    assign o_rst       = use_b ? rst3        : rst;
    assign o_s_ready   = use_b ? b_s_ready   : a_s_ready;
    assign o_m_valid   = use_b ? b_m_valid   : a_m_valid;
    assign o_m_last    = use_b ? b_m_last    : a_m_last;
    assign o_m_data    = use_b ? b_m_data    : a_m_data;
    assign o_load_en   = use_b ? b_load_en   : a_load_en;
    assign o_sel_ab    = use_b ? b_sel_ab    : a_sel_ab;
    assign o_index     = use_b ? b_index     : a_index;
    assign o_in_data   = use_b ? b_in_data   : a_in_data;
    assign o_output_en = use_b ? b_output_en : a_output_en;
    assign o_out_sel   = use_b ? b_out_sel   : a_out_sel;
    assign o_busy      = use_b ? b_busy      : a_busy;
    assign o_tmo       = use_b ? b_tmo       : a_tmo;
    assign o_state     = use_b ? b_state     : a_state;

    // Controller model: read data is combinational on the read strobe.
    always_comb begin
        ctl_out_data = 8'h00;
        if (o_output_en) begin
            case (o_out_sel)
                2'd0:    ctl_out_data = bfm_res[31:24];
                2'd1:    ctl_out_data = bfm_res[23:16];
                2'd2:    ctl_out_data = bfm_res[15:8];
                default: ctl_out_data = bfm_res[7:0];
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [8:0]  exp_q[$];     // {last, data} per result beat
    logic [10:0] exp_ld_q[$];  // {sel_ab, index, data} per load strobe
    int ld_cyc_q[$];
    int rd_cyc_q[$];
    int rd_sel_q[$];
    int done_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: sample mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!o_rst) begin
            if (o_load_en) begin
                ld_cyc_q.push_back(cyc);
                if (exp_ld_q.size() == 0) check("ld_extra", 1, 0);
                else check("ld", {o_sel_ab, o_index, o_in_data}, exp_ld_q.pop_front());
            end
            if (o_output_en) begin
                rd_cyc_q.push_back(cyc);
                rd_sel_q.push_back(int'(o_out_sel));
            end
            if (o_m_valid && m_ready) begin
                if (exp_q.size() == 0) check("out_extra", 1, 0);
                else check("out", {o_m_last, o_m_data}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready", o_s_ready, 1);   check("rst_m_valid", o_m_valid, 0);
        check("rst_m_last", o_m_last, 0);     check("rst_m_data", o_m_data, 0);
        check("rst_ld_en", o_load_en, 0);     check("rst_sel_ab", o_sel_ab, 0);
        check("rst_index", o_index, 0);       check("rst_in_data", o_in_data, 0);
        check("rst_out_en", o_output_en, 0);  check("rst_out_sel", o_out_sel, 0);
        check("rst_busy", o_busy, 0);         check("rst_tmo", o_tmo, 0);
        check("rst_state", o_state, LOAD);
    endtask

    // bytes: A0 in the top byte ... B3 in the bottom byte.
    task automatic send_job(input logic [63:0] bytes, input bit gaps);
        logic [7:0] b;
        logic [2:0] k3;
        int w;
        for (int k = 0; k < 8; k++) begin
            b  = bytes[8*(7-k) +: 8];
            k3 = 3'(k);
            exp_ld_q.push_back({k3[2], k3[1:0], b});
            s_valid = 1'b1;
            s_data  = b;
            w = 0;
            while (!o_s_ready && w < 40) begin step(); w++; end
            if (w >= 40) check("s_ready_wait", 0, 1);
            step();
            if (gaps && k < 7) begin
                s_valid = 1'b0;
                step();
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic done_and_reads(input int rd);
        int w;
        repeat (3) step();
        rd_cyc_q.delete();
        rd_sel_q.delete();
        ctl_done = 1'b1;
        done_cyc = cyc;
        step();
        ctl_done = 1'b0;
        w = 0;
        while (rd_cyc_q.size() < 4 && w < 30) begin step(); w++; end
        check("rd_count", rd_cyc_q.size(), 4);
        for (int i = 0; i < rd_cyc_q.size() && i < 4; i++) begin
            check("rd_cyc", rd_cyc_q[i] - done_cyc, rd + i);
            check("rd_sel", rd_sel_q[i], i);
        end
    endtask

    task automatic drain(input int stall, input logic [7:0] first);
        int w;
        m_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            check("hold_valid", o_m_valid, 1);
            check("hold_data", o_m_data, first);
            check("hold_s_ready", o_s_ready, 0);
            step();
        end
        m_ready = 1'b1;
        w = 0;
        while (exp_q.size() > 0 && w < 30) begin
            step();
            w++;
            if (exp_q.size() > 0) check("drain_s_ready", o_s_ready, 0);
        end
        m_ready = 1'b0;
        check("drain_left", exp_q.size(), 0);
        check("post_s_ready", o_s_ready, 1);
        check("post_busy", o_busy, 0);
        check("rd_total", rd_cyc_q.size(), 4);
    endtask

    task automatic run_job(input logic [63:0] bytes, input bit gaps, input logic [31:0] res,
                           input int rd, input int stall);
        ld_cyc_q.delete();
        bfm_res = res;
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), res[8*(3-i) +: 8]});
        send_job(bytes, gaps);
        done_and_reads(rd);
        drain(stall, res[31:24]);
        check("ld_total", ld_cyc_q.size(), 8);
        if (ld_cyc_q.size() == 8) begin
            check("ld_span", ld_cyc_q[7] - ld_cyc_q[0], gaps ? 14 : 7);
            check("ld_gap", ld_cyc_q[1] - ld_cyc_q[0], gaps ? 2 : 1);
        end
    endtask

    localparam logic [63:0] JOB1 = 64'h38404448_38383838;
    localparam logic [63:0] JOB2 = 64'h01020304_05060708;

    // ---------------- test sequence ----------------
    initial begin
        int w;
        repeat (3) step();
        rst = 1'b0;
        step();
        check_reset_vals();

        // Directed job, no backpressure.
        run_job(JOB1, 1'b0, 32'h11223344, 2, 0);

        // Output backpressure: m_ready low for 10 DRAIN cycles.
        run_job(JOB2, 1'b0, 32'h11223344, 2, 10);

        // Input gaps: s_valid 1,0,1,0...
        run_job(JOB1, 1'b1, 32'hA1B2C3D4, 2, 0);

        // Timeout: no done after the 8 loads.
        ld_cyc_q.delete();
        send_job(JOB2, 1'b0);
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || i == 14) begin
                check("tmo_early", o_tmo, 0);
                check("tmo_busy", o_busy, 1);
            end
            step();
        end
        check("tmo_set", o_tmo, 1);
        check("tmo_state", o_state, LOAD);
        check("tmo_s_ready", o_s_ready, 1);
        check("tmo_ld", ld_cyc_q.size(), 8);
        run_job(JOB1, 1'b0, 32'h0F1E2D3C, 2, 0);
        check("tmo_sticky", o_tmo, 1);

        // Reset in the middle of the read burst (after sel 1).
        ld_cyc_q.delete();
        bfm_res = 32'h99AABBCC;
        send_job(JOB2, 1'b0);
        repeat (3) step();
        rd_cyc_q.delete();
        ctl_done = 1'b1;
        step();
        ctl_done = 1'b0;
        w = 0;
        while (rd_cyc_q.size() < 2 && w < 20) begin step(); w++; end
        check("mid_rd_en", o_output_en, 1);
        check("mid_rd_sel", o_out_sel, 2);
        rst = 1'b1;
        #1;
        check_reset_vals();
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_ld_q.delete();
        step();
        run_job(JOB1, 1'b0, 32'h55667788, 2, 0);

        // READ_DELAY=3 instance, with a spurious done while in LOAD.
        rst   = 1'b1;
        use_b = 1'b1;
        step();
        rst3 = 1'b0;
        step();
        check_reset_vals();
        rd_cyc_q.delete();
        ctl_done = 1'b1;
        step();
        ctl_done = 1'b0;
        repeat (4) step();
        check("spur_state", o_state, LOAD);
        check("spur_s_ready", o_s_ready, 1);
        check("spur_busy", o_busy, 0);
        check("spur_reads", rd_cyc_q.size(), 0);
        run_job(JOB2, 1'b0, 32'hDEADBEEF, 3, 2);

        check("final_exp_q", exp_q.size(), 0);
        check("final_exp_ld_q", exp_ld_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
